// File: rtl/sopc_run_ctrl.sv
// -----------------------------------------------------------------------------
// sopc_run_ctrl
//
// Run controller for a small SoPC. After reset it holds every core reset
// channel asserted for RST_HOLD cycles and then releases the channels one by
// one, STAGGER cycles apart. It then lets the cores run while counting run
// cycles. A run ends either on a halt request from the core or when the
// cycle budget is used up. The block then sits in DONE until it is told to
// restart.
//
// Ports
//   clk          system clock; every state change happens on its rising edge
//   rst          synchronous, active-high reset
//   halt_i       halt request from the core; only looked at in RUN
//   restart_i    re-run request; only looked at in DONE
//   core_rst_o   per-channel core reset, active-high, registered
//   running_o    high while in RUN
//   done_o       high in DONE after a halt_i stop
//   timeout_o    high in DONE after a budget stop
//   stall_o      high in DONE when HALT_RESETS=0 (cores stay out of reset)
//   cycle_cnt_o  number of RUN cycles elapsed in the current run
// -----------------------------------------------------------------------------
module sopc_run_ctrl #(
    parameter int NUM_CH      = 2,    // 1..8
    parameter int RST_HOLD    = 10,   // >= 1
    parameter int STAGGER     = 1,    // 0 releases all channels together
    parameter int RUN_LIMIT   = 500,  // 0 disables the timeout
    parameter int CNT_W       = 32,
    parameter int HALT_RESETS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_i,
    input  logic              restart_i,
    output logic [NUM_CH-1:0] core_rst_o,
    output logic              running_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);

    // Edge on which the last channel leaves reset. When every channel
    // releases together, this is the same edge as the channel 0 release.
    localparam int LAST_EDGE = RST_HOLD + (NUM_CH - 1) * STAGGER;
    localparam int SEQ_W     = (LAST_EDGE < 1) ? 1 : $clog2(LAST_EDGE + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(RUN_LIMIT);

    typedef enum logic [1:0] {
        S_HOLD,
        S_STAGGER,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_CH-1:0]  core_rst_q, core_rst_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;      // release edges seen so far
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    int                 edge_num;          // number of the edge being evaluated

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HOLD;
            core_rst_q <= '1;
            seq_q      <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            core_rst_q <= core_rst_d;
            seq_q      <= seq_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first. A path that
    // does not assign a signal would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        core_rst_d = core_rst_q;
        seq_d      = seq_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        edge_num   = int'(seq_q) + 1;

        unique case (state_q)
            S_HOLD, S_STAGGER: begin
                seq_d = seq_q + 1'b1;
                // Once a channel's release edge has been reached it stays released.
                for (int i = 0; i < NUM_CH; i++) begin
                    if (edge_num >= RST_HOLD + i * STAGGER) begin
                        core_rst_d[i] = 1'b0;
                    end
                end
                // The LAST_EDGE test comes first. With one channel or STAGGER=0,
                // LAST_EDGE equals RST_HOLD and HOLD goes straight to RUN.
                if (edge_num == LAST_EDGE) begin
                    state_d = S_RUN;
                end else if (edge_num == RST_HOLD) begin
                    state_d = S_STAGGER;
                end
            end

            S_RUN: begin
                // A halt has priority over a budget stop on the same edge.
                if (halt_i) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (RUN_LIMIT != 0 && cnt_q == CNT_LIMIT - 1'b1) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    cnt_d     = CNT_LIMIT;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (state_d == S_DONE && HALT_RESETS != 0) begin
                    core_rst_d = '1;
                end
            end

            S_DONE: begin
                if (restart_i) begin
                    state_d    = S_HOLD;
                    core_rst_d = '1;
                    seq_d      = '0;
                    cnt_d      = '0;
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                end
            end

            default: state_d = S_HOLD;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign core_rst_o  = core_rst_q;
    assign running_o   = (state_q == S_RUN);
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign stall_o     = (state_q == S_DONE) && (HALT_RESETS == 0);
    assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sopc_run_ctrl
//
// Directed bench for sopc_run_ctrl. It uses two instances:
//   dut_a  default parameters (2 channels, hold 10, stagger 1, budget 500)
//   dut_b  4 channels, STAGGER=0, RUN_LIMIT=0, HALT_RESETS=0, 4-bit counter.
//          The narrow counter reaches all-ones quickly, so saturation can be
//          shown in a short run.
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same
// point, so "after edge k" means the values seen right after the k-th tick.
// -----------------------------------------------------------------------------
module tb_sopc_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // dut_a: default parameters
    logic        rst_a, halt_a, restart_a;
    logic [1:0]  core_rst_a;
    logic        running_a, done_a, timeout_a, stall_a;
    logic [31:0] cnt_a;

    sopc_run_ctrl dut_a (
        .clk         (clk),
        .rst         (rst_a),
        .halt_i      (halt_a),
        .restart_i   (restart_a),
        .core_rst_o  (core_rst_a),
        .running_o   (running_a),
        .done_o      (done_a),
        .timeout_o   (timeout_a),
        .stall_o     (stall_a),
        .cycle_cnt_o (cnt_a)
    );

    // dut_b: all channels together, no timeout, no reset reassert, narrow counter
    logic        rst_b, halt_b, restart_b;
    logic [3:0]  core_rst_b;
    logic        running_b, done_b, timeout_b, stall_b;
    logic [3:0]  cnt_b;

    sopc_run_ctrl #(
        .NUM_CH      (4),
        .RST_HOLD    (10),
        .STAGGER     (0),
        .RUN_LIMIT   (0),
        .CNT_W       (4),
        .HALT_RESETS (0)
    ) dut_b (
        .clk         (clk),
        .rst         (rst_b),
        .halt_i      (halt_b),
        .restart_i   (restart_b),
        .core_rst_o  (core_rst_b),
        .running_o   (running_b),
        .done_o      (done_b),
        .timeout_o   (timeout_b),
        .stall_o     (stall_b),
        .cycle_cnt_o (cnt_b)
    );

    // Status packed as {core_rst, running, done, timeout, stall}
    function automatic logic [5:0] st_a();
        return {core_rst_a, running_a, done_a, timeout_a, stall_a};
    endfunction

    function automatic logic [7:0] st_b();
        return {core_rst_b, running_b, done_b, timeout_b, stall_b};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Release sequence of dut_a from k=1 through k=11. With noise=1, halt_i and
    // restart_i are held high through edge 10 and must have no effect.
    task automatic release_a(input bit noise, input string tag);
        logic [5:0] exp;
        for (int k = 1; k <= 11; k++) begin
            halt_a    = noise && (k <= 10);
            restart_a = noise && (k <= 10);
            tick();
            exp = (k < 10) ? 6'b11_0000 : (k == 10) ? 6'b10_0000 : 6'b00_1000;
            checks++;
            if (st_a() !== exp) begin
                errors++;
                $display("FAIL %s edge %0d status: got %b want %b", tag, k, st_a(), exp);
            end
        end
        halt_a    = 1'b0;
        restart_a = 1'b0;
        checks++;
        if (cnt_a !== 32'd0) begin
            errors++;
            $display("FAIL %s first run cycle count: got %0d want 0", tag, cnt_a);
        end
    endtask

    task automatic restart_pulse_a();
        restart_a = 1'b1;
        tick();
        restart_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; halt_a = 1'b0; restart_a = 1'b0;
        rst_b = 1'b1; halt_b = 1'b0; restart_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (st_a() !== 6'b11_0000 || cnt_a !== 32'd0) begin
                errors++;
                $display("FAIL reset edge %0d: got status %b cnt %0d want 110000 cnt 0", i, st_a(), cnt_a);
            end
        end
        rst_a = 1'b0;
    endtask

    task automatic test_release();
        release_a(1'b0, "release");
    endtask

    task automatic test_halt();
        tick(37);
        checks++;
        if (cnt_a !== 32'd37 || st_a() !== 6'b00_1000) begin
            errors++;
            $display("FAIL halt pre-count: got cnt %0d status %b want 37 001000", cnt_a, st_a());
        end
        halt_a = 1'b1;
        tick();
        halt_a = 1'b0;
        checks++;
        if (st_a() !== 6'b11_0100 || cnt_a !== 32'd37) begin
            errors++;
            $display("FAIL halt stop: got status %b cnt %0d want 110100 cnt 37", st_a(), cnt_a);
        end
        // DONE persists; a halt in DONE is ignored.
        halt_a = 1'b1;
        tick(5);
        halt_a = 1'b0;
        checks++;
        if (st_a() !== 6'b11_0100 || cnt_a !== 32'd37) begin
            errors++;
            $display("FAIL halt persist: got status %b cnt %0d want 110100 cnt 37", st_a(), cnt_a);
        end
        restart_pulse_a();
        checks++;
        if (st_a() !== 6'b11_0000 || cnt_a !== 32'd0) begin
            errors++;
            $display("FAIL restart: got status %b cnt %0d want 110000 cnt 0", st_a(), cnt_a);
        end
        release_a(1'b1, "rerun");
    endtask

    task automatic test_timeout();
        tick(499);
        checks++;
        if (cnt_a !== 32'd499 || st_a() !== 6'b00_1000) begin
            errors++;
            $display("FAIL timeout pre: got cnt %0d status %b want 499 001000", cnt_a, st_a());
        end
        tick();
        checks++;
        if (st_a() !== 6'b11_0010 || cnt_a !== 32'd500) begin
            errors++;
            $display("FAIL timeout stop: got status %b cnt %0d want 110010 cnt 500", st_a(), cnt_a);
        end
        restart_pulse_a();
        release_a(1'b0, "after_timeout");
    endtask

    task automatic test_halt_vs_timeout();
        tick(499);
        halt_a = 1'b1;
        tick();
        halt_a = 1'b0;
        checks++;
        if (st_a() !== 6'b11_0100 || cnt_a !== 32'd499) begin
            errors++;
            $display("FAIL halt_vs_timeout: got status %b cnt %0d want 110100 cnt 499", st_a(), cnt_a);
        end
        restart_pulse_a();
    endtask

    task automatic test_reset_mid();
        // Into STAGGER: channel 0 released, channel 1 still held.
        tick(10);
        checks++;
        if (st_a() !== 6'b10_0000) begin
            errors++;
            $display("FAIL mid stagger status: got %b want 100000", st_a());
        end
        rst_a = 1'b1;
        tick();
        checks++;
        if (st_a() !== 6'b11_0000 || cnt_a !== 32'd0) begin
            errors++;
            $display("FAIL rst in stagger: got status %b cnt %0d want 110000 cnt 0", st_a(), cnt_a);
        end
        tick(3);
        checks++;
        if (st_a() !== 6'b11_0000 || cnt_a !== 32'd0) begin
            errors++;
            $display("FAIL rst held: got status %b cnt %0d want 110000 cnt 0", st_a(), cnt_a);
        end
        rst_a = 1'b0;
        release_a(1'b0, "after_rst_stagger");
        // A restart in RUN is ignored; counting continues.
        restart_a = 1'b1;
        tick(5);
        restart_a = 1'b0;
        checks++;
        if (cnt_a !== 32'd5 || st_a() !== 6'b00_1000) begin
            errors++;
            $display("FAIL restart in run: got cnt %0d status %b want 5 001000", cnt_a, st_a());
        end
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        checks++;
        if (st_a() !== 6'b11_0000 || cnt_a !== 32'd0) begin
            errors++;
            $display("FAIL rst in run: got status %b cnt %0d want 110000 cnt 0", st_a(), cnt_a);
        end
        release_a(1'b0, "after_rst_run");
    endtask

    task automatic test_all_together();
        logic [7:0] exp;
        // dut_b has been in reset the whole time.
        checks++;
        if (st_b() !== 8'b1111_0000 || cnt_b !== 4'd0) begin
            errors++;
            $display("FAIL b held reset: got status %b cnt %0d want 11110000 cnt 0", st_b(), cnt_b);
        end
        rst_b = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = (k < 10) ? 8'b1111_0000 : 8'b0000_1000;
            checks++;
            if (st_b() !== exp) begin
                errors++;
                $display("FAIL b release edge %0d: got %b want %b", k, st_b(), exp);
            end
        end
        tick(15);
        checks++;
        if (cnt_b !== 4'd15) begin
            errors++;
            $display("FAIL b count at max: got %0d want 15", cnt_b);
        end
        tick(5);
        checks++;
        if (cnt_b !== 4'd15 || st_b() !== 8'b0000_1000) begin
            errors++;
            $display("FAIL b saturate: got cnt %0d status %b want 15 00001000", cnt_b, st_b());
        end
        halt_b = 1'b1;
        tick();
        halt_b = 1'b0;
        checks++;
        if (st_b() !== 8'b0000_0101 || cnt_b !== 4'd15) begin
            errors++;
            $display("FAIL b halt stall: got status %b cnt %0d want 00000101 cnt 15", st_b(), cnt_b);
        end
        restart_b = 1'b1;
        tick();
        restart_b = 1'b0;
        checks++;
        if (st_b() !== 8'b1111_0000 || cnt_b !== 4'd0) begin
            errors++;
            $display("FAIL b restart: got status %b cnt %0d want 11110000 cnt 0", st_b(), cnt_b);
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_halt();
        test_timeout();
        test_halt_vs_timeout();
        test_reset_mid();
        test_all_together();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sopc_run_ctrl.md
SOPC_RUN_CTRL -- requirements
Module: sopc_run_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent core reset channels; legal range 1..8.
REQ-002 Parameter RST_HOLD, default 10: cycles that channel 0 stays in reset after rst deasserts; minimum 1.
REQ-003 Parameter STAGGER, default 1: cycles between releases of consecutive channels; 0 releases all channels together.
REQ-004 Parameter RUN_LIMIT, default 500: run-cycle budget before timeout; 0 disables the timeout.
REQ-005 Parameter CNT_W, default 32: width of the run-cycle counter.
REQ-006 Parameter HALT_RESETS, default 1: 1 reasserts all core resets in DONE; 0 keeps them released and asserts stall_o instead.
REQ-007 clk  input  1  single system clock; all state changes on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 halt_i  input  1  halt request from the core (trap or exception-stop), sampled only in RUN.
REQ-010 restart_i  input  1  re-run request, sampled only in DONE.
REQ-011 core_rst_o  output  NUM_CH  per-channel core reset, active-high, registered.
REQ-012 running_o  output  1  high while in RUN.
REQ-013 done_o  output  1  high in DONE after a halt_i stop.
REQ-014 timeout_o  output  1  high in DONE after a budget stop.
REQ-015 stall_o  output  1  high in DONE when HALT_RESETS=0; otherwise always 0.
REQ-016 cycle_cnt_o  output  CNT_W  number of RUN cycles elapsed in the current run.

Function
REQ-017 The FSM SHALL have four states: HOLD, STAGGER, RUN and DONE.
REQ-018 Count the rising edges with rst=0 as k=1,2,...; core_rst_o[i] SHALL drop after edge RST_HOLD+i*STAGGER.
REQ-019 HOLD SHALL go to STAGGER when channel 0 releases; it SHALL go directly to RUN if NUM_CH=1 or STAGGER=0.
REQ-020 STAGGER SHALL go to RUN on the edge that releases channel NUM_CH-1; running_o SHALL rise on that same edge.
REQ-021 In RUN, cycle_cnt_o SHALL increment by 1 per cycle, starting from 0 on the first RUN cycle.
REQ-022 When RUN_LIMIT=0, cycle_cnt_o SHALL saturate at all-ones and SHALL NOT wrap.
REQ-023 halt_i=1 in RUN SHALL cause, on the next edge: state DONE, done_o=1, running_o=0, and cycle_cnt_o frozen at its pre-edge value.
REQ-024 If RUN_LIMIT!=0 and the edge would take cycle_cnt_o to RUN_LIMIT, the block SHALL go to DONE with timeout_o=1 and cycle_cnt_o=RUN_LIMIT.
REQ-025 When halt_i and the timeout coincide, halt SHALL win: done_o=1 and timeout_o=0.
REQ-026 On entry to DONE with HALT_RESETS=1, core_rst_o SHALL become all ones.
REQ-027 On entry to DONE with HALT_RESETS=0, core_rst_o SHALL stay all zeros and stall_o SHALL become 1.
REQ-028 restart_i=1 in DONE SHALL cause HOLD on the next edge: core_rst_o all ones, done/timeout/stall cleared, cycle_cnt_o=0, sequence restarts at k=1.
REQ-029 restart_i SHALL be ignored outside DONE, and halt_i SHALL be ignored outside RUN.
REQ-030 DONE SHALL persist indefinitely until restart_i or rst.

Reset
REQ-031 rst=1 on any edge, in any state, SHALL force on that edge: state HOLD, core_rst_o all ones, running_o, done_o, timeout_o and stall_o = 0, cycle_cnt_o=0, and all internal counters cleared.
REQ-032 Reset asserted mid-sequence or mid-run SHALL abort the sequence with no partial channel release retained.
REQ-033 Outputs SHALL hold their reset values for as long as rst stays high.

Verification
REQ-034 Defaults, rst high for 10 edges then low: core_rst_o = 2'b11 through edge 9, 2'b10 after edge 10, 2'b00 and running_o=1 after edge 11.
REQ-035 Defaults, halt_i pulsed for 1 cycle when cycle_cnt_o=37: next edge gives done_o=1, cycle_cnt_o=37, core_rst_o=2'b11; restart_i then repeats the REQ-034 timing.
REQ-036 Defaults, no halt_i: timeout_o=1 with cycle_cnt_o=500 exactly 500 edges after running_o rises.
REQ-037 halt_i asserted on the budget edge (cycle_cnt_o=499): done_o=1 and timeout_o=0.
REQ-038 NUM_CH=4, STAGGER=0, HALT_RESETS=0, RUN_LIMIT=0: all channels release at edge 10; after halt_i, stall_o=1 and core_rst_o=4'b0000; the counter never wraps when forced near all-ones.
REQ-039 rst asserted during STAGGER and during RUN: outputs return to reset values on the same edge, and the release timing restarts from k=1.
